// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control unit. It detects hazards, drives the stall and
// bubble signals for the pipeline registers, and owns the condition codes,
// the sticky halt flag and the cycle/stall performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic             set_cc,
    input  logic [2:0]       new_cc,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [2:0]       CC_RESET = 3'b100;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             loaduse;
    logic             mispred;
    logic             ret_any;
    logic             m_exc;
    logic             w_exc;

    logic [2:0]       cc_q, cc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Hazard detection from the current stage contents.
    always_comb begin
        loaduse = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred = (E_icode == I_JXX) && !e_Cnd;
        ret_any = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        m_exc   = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
        w_exc   = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    end

    // Pipeline-register controls; reset flushes E/M, halt freezes everything.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        if (reset) begin
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (halted_q) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end else begin
            // A load/use stall keeps the ret instruction in decode, so it
            // must not also be replaced by a bubble.
            F_stall  = loaduse || ret_any;
            D_stall  = loaduse;
            D_bubble = mispred || (ret_any && !loaduse);
            E_bubble = mispred || loaduse;
            M_bubble = m_exc || w_exc;
            W_stall  = w_exc;
        end
    end

    // Next state for condition codes, halt flag and counters.
    always_comb begin
        cc_d        = cc_q;
        halted_d    = halted_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!halted_q) begin
            // An exception further down the pipe squashes the CC update.
            if (set_cc && (E_icode == I_OPQ) && !m_exc && !w_exc) begin
                cc_d = new_cc;
            end
            if (w_exc) begin
                // The edge that enters the halted state is not counted.
                halted_d = 1'b1;
            end else begin
                cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                if (loaduse || ret_any) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cc_q        <= CC_RESET;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cc_q        <= cc_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cc        = cc_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
